// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto one memory port, one transaction outstanding.
// Grant in 1 cycle from request; each requester keeps one pending slot and extra requests are dropped (err[0]).
module mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_oe,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_oe,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [3:0]    d_we,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_oe,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [3:0]    m_we,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic [1:0]    err
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state;
    logic          i_slot_vld;
    logic [AW-1:0] i_slot_addr;
    logic          d_slot_vld;
    logic [AW-1:0] d_slot_addr;
    logic [DW-1:0] d_slot_wdata;
    logic [3:0]    d_slot_we;
    logic [SW-1:0] streak;

    logic          arb;
    logic          i_cand;
    logic          d_cand;
    logic          grant_i;
    logic          grant_d;
    logic [AW-1:0] gi_addr;
    logic [AW-1:0] gd_addr;
    logic [DW-1:0] gd_wdata;
    logic [3:0]    gd_we;

    // Arbitration also happens on the completing edge so grants run back-to-back.
    assign arb      = (state == IDLE) || m_ready;
    assign i_cand   = i_slot_vld || i_oe;
    assign d_cand   = d_slot_vld || d_oe;
    assign grant_i  = arb && i_cand && (!d_cand || (streak == SW'(MAX_DSTREAK)));
    assign grant_d  = arb && d_cand && !grant_i;

    // The slot holds the older request, so it is served before an incoming one.
    assign gi_addr  = i_slot_vld ? i_slot_addr  : i_addr;
    assign gd_addr  = d_slot_vld ? d_slot_addr  : d_addr;
    assign gd_wdata = d_slot_vld ? d_slot_wdata : d_wdata;
    assign gd_we    = d_slot_vld ? d_slot_we    : d_we;

    assign i_ready  = (state == BUSY_I) && m_ready;
    assign d_ready  = (state == BUSY_D) && m_ready;
    assign i_rdata  = (state == BUSY_I) ? m_rdata : '0;
    assign d_rdata  = (state == BUSY_D) ? m_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            i_slot_vld   <= 1'b0;
            i_slot_addr  <= '0;
            d_slot_vld   <= 1'b0;
            d_slot_addr  <= '0;
            d_slot_wdata <= '0;
            d_slot_we    <= '0;
            streak       <= '0;
            m_oe         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            m_we         <= '0;
            err          <= '0;
        end else begin
            m_oe <= grant_i || grant_d;

            if (grant_i) begin
                m_addr  <= gi_addr;
                m_wdata <= '0;
                m_we    <= '0;
                state   <= BUSY_I;
            end else if (grant_d) begin
                m_addr  <= gd_addr;
                m_wdata <= gd_wdata;
                m_we    <= gd_we;
                state   <= BUSY_D;
            end else if (state != IDLE && m_ready) begin
                state   <= IDLE;
            end

            if (state == IDLE && m_ready) begin
                err[1] <= 1'b1;
            end

            i_slot_vld <= grant_i ? (i_slot_vld && i_oe) : (i_slot_vld || i_oe);
            if (i_oe && (!i_slot_vld || grant_i)) begin
                i_slot_addr <= i_addr;
            end
            if (i_oe && i_slot_vld && !grant_i) begin
                err[0] <= 1'b1;
            end

            d_slot_vld <= grant_d ? (d_slot_vld && d_oe) : (d_slot_vld || d_oe);
            if (d_oe && (!d_slot_vld || grant_d)) begin
                d_slot_addr  <= d_addr;
                d_slot_wdata <= d_wdata;
                d_slot_we    <= d_we;
            end
            if (d_oe && d_slot_vld && !grant_d) begin
                err[0] <= 1'b1;
            end

            if (grant_i || !i_cand) begin
                streak <= '0;
            end else if (grant_d && streak != SW'(MAX_DSTREAK)) begin
                streak <= streak + SW'(1);
            end
        end
    end

endmodule
